wavegen_dds: RTL and testbench
==============================

# wavegen_dds

Parametrised multi-mode waveform generator for the oscilloscope/signal-generator datapath. A phase accumulator (DDS) replaces the external frequency toggle. The block produces square (with duty control), triangle, sawtooth or DC samples. Output is `bias ± p2p/2`, saturated to the DAC range, with glitch-free parameter updates at period boundaries. It drives the DAC sample register directly.

## Interface
- `DW`, 12: DAC sample width in bits.
- `PW`, 24: phase accumulator width in bits; must satisfy PW ≥ DW+2.
- `clk` in 1: sample clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: advance the phase accumulator.
- `mode` in 2: waveform select: 0 square, 1 triangle, 2 sawtooth, 3 DC.
- `phase_inc` in PW: phase step per clock, unsigned. Output frequency = f_clk·phase_inc/2^PW.
- `duty` in 8: square high fraction, duty/256.
- `bias` in DW: waveform centre, unsigned.
- `p2p` in DW: peak-to-peak amplitude, unsigned.
- `data_out` out DW: DAC sample, registered.
- `cycle_start` out 1: one-cycle pulse on the first sample of each new period.
- `clip` out 1: current `data_out` was saturated.

## Operation
- Accumulator `acc` (PW bits): `acc <= acc + phase_inc` mod 2^PW when `en`=1; holds when `en`=0. `wrap` = carry out of that addition, qualified by `en`.
- Shadow registers hold `mode`, `duty`, `bias`, `p2p` and `phase_inc`. They load from the ports in any cycle where `en`=0 or `wrap`=1, and hold otherwise. Port changes during a period therefore take effect only at the next period. On `wrap`, shadow `phase_inc` loads together with the others; the new increment applies from the next step.
- Shape, from the acc value A:
  - Square: `high` = A[PW-1:PW-8] < duty. duty=0 gives always low.
  - Sawtooth: r = A[PW-1 -: DW].
  - Triangle: t = A[PW-2 -: DW] when A[PW-1]=0; otherwise the bitwise inverse of A[PW-2 -: DW].
- Output value, computed signed at DW+2 bits, with h = p2p>>1 (floor):
  - Square: high gives bias+h; low gives bias−h.
  - Sawtooth: bias − h + ((p2p·r)>>DW).
  - Triangle: bias − h + ((p2p·t)>>DW).
  - DC: bias.
- Saturation: result <0 gives 0 with `clip`=1; result >2^DW−1 gives 2^DW−1 with `clip`=1; otherwise `clip`=0.

## Timing
- Two-stage pipeline after `acc`:
  - Stage 1 registers the shape, the DW×DW product (2·DW bits), the square bit and the delayed `wrap`.
  - Stage 2 registers the add/clamp into `data_out`, `clip` and `cycle_start`.
- `data_out`, `clip` and `cycle_start` at cycle n+2 are a function of A and the shadow registers at cycle n. `cycle_start` is coincident with the sample computed from the first post-wrap A.
- `en`=0: `acc` freezes and the pipeline keeps running. The output settles to the held phase within 2 cycles, using live port values (shadow registers are transparent while `en`=0). `cycle_start` stays 0.
- Reset, asynchronous at any time including mid-period: `acc`, all shadow registers, all pipeline stages, `data_out`, `clip` and `cycle_start` go to 0 immediately. The first sample after release follows the rules above.
- phase_inc=0 with `en`=1: output is static and `cycle_start` is never asserted.
- Simultaneous port change and `wrap`: the new value is captured and used from the first post-wrap sample.

## Test plan
- Reset mid-run: assert `rst` asynchronously while the square wave outputs 2548. `data_out`, `clip` and `cycle_start` read 0 within the same cycle and hold until release.
- Square: with `en`=0 load mode=0, bias=2048, p2p=1000, duty=128, phase_inc=2^20, then set `en`=1. Output repeats 8×2548, 8×1548 (period 16). `cycle_start` pulses every 16 cycles on the first 2548 sample. `clip`=0.
- Clamp: as the square test but bias=100. Low samples read 0 with `clip`=1; high samples read 600 with `clip`=0.
- Sawtooth: mode=2, bias=2048, p2p=4095, phase_inc=2^12. Output runs 1, 1+((4095·1)>>12)=1, 2, … reaching 4095 at r=4095, then returns to 1 with `cycle_start`.
- Triangle: mode=1, bias=2048, p2p=2048, phase_inc=2^20. First half reads 1024, 1280, …, 2816. Second half reads 3071, 2815, …, 1279.
- Glitch-free update: mid-period of the square test, change p2p to 2000 with `en`=1. Old levels persist until `cycle_start`. The next period reads 3048/1048.

Source files
------------

// File: rtl/wavegen_dds.sv
// Phase-accumulator waveform generator: square/triangle/saw/DC.
// Shadowed parameters update only at period wrap; output saturates.
module wavegen_dds #(
  parameter int DW = 12,
  parameter int PW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] phase_inc,
  input  logic [7:0]    duty,
  input  logic [DW-1:0] bias,
  input  logic [DW-1:0] p2p,
  output logic [DW-1:0] data_out,
  output logic          cycle_start,
  output logic          clip
);

  localparam int XW = DW + 2;

  logic [PW-1:0]   r_acc;
  logic            r_wrap;
  logic [1:0]      r_mode;
  logic [7:0]      r_duty;
  logic [DW-1:0]   r_bias;
  logic [DW-1:0]   r_p2p;
  logic [PW-1:0]   r_inc;

  logic [PW:0]     w_sum;
  logic            w_wrap;
  logic            w_load;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_wrap = en & w_sum[PW];
  assign w_load = ~en | w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
      r_mode <= '0;
      r_duty <= '0;
      r_bias <= '0;
      r_p2p  <= '0;
      r_inc  <= '0;
    end else begin
      if (en)
        r_acc <= w_sum[PW-1:0];
      r_wrap <= w_wrap;
      if (w_load) begin
        r_mode <= mode;
        r_duty <= duty;
        r_bias <= bias;
        r_p2p  <= p2p;
        r_inc  <= phase_inc;
      end
    end
  end

  // While frozen the shadows are bypassed so edits show up at once.
  logic [1:0]      w_mode;
  logic [7:0]      w_duty;
  logic [DW-1:0]   w_bias;
  logic [DW-1:0]   w_p2p;

  assign w_mode = en ? r_mode : mode;
  assign w_duty = en ? r_duty : duty;
  assign w_bias = en ? r_bias : bias;
  assign w_p2p  = en ? r_p2p  : p2p;

  logic [DW-1:0]   w_saw;
  logic [DW-1:0]   w_tri;
  logic [DW-1:0]   w_shape;
  logic [2*DW-1:0] w_prod;
  logic            w_sq;

  assign w_saw   = r_acc[PW-1 -: DW];
  assign w_tri   = r_acc[PW-1] ? ~r_acc[PW-2 -: DW]
                               :  r_acc[PW-2 -: DW];
  assign w_shape = (w_mode == 2'd1) ? w_tri : w_saw;
  assign w_prod  = (2*DW)'(w_p2p) * (2*DW)'(w_shape);
  assign w_sq    = r_acc[PW-1 -: 8] < w_duty;

  logic [2*DW-1:0] r_s1_prod;
  logic            r_s1_sq;
  logic            r_s1_wrap;
  logic [1:0]      r_s1_mode;
  logic [DW-1:0]   r_s1_bias;
  logic [DW-1:0]   r_s1_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_prod <= '0;
      r_s1_sq   <= 1'b0;
      r_s1_wrap <= 1'b0;
      r_s1_mode <= '0;
      r_s1_bias <= '0;
      r_s1_h    <= '0;
    end else begin
      r_s1_prod <= w_prod;
      r_s1_sq   <= w_sq;
      r_s1_wrap <= r_wrap;
      r_s1_mode <= w_mode;
      r_s1_bias <= w_bias;
      r_s1_h    <= w_p2p >> 1;
    end
  end

  logic [XW-1:0]   w_lo;
  logic [XW-1:0]   w_hi;
  logic [XW-1:0]   w_scaled;
  logic [XW-1:0]   w_val;

  // Two's complement in XW bits: MSB flags a negative result.
  assign w_lo     = XW'(r_s1_bias) - XW'(r_s1_h);
  assign w_hi     = XW'(r_s1_bias) + XW'(r_s1_h);
  assign w_scaled = XW'(r_s1_prod >> DW);

  always_comb begin
    w_val = w_lo;
    unique case (r_s1_mode)
      2'd0: w_val = r_s1_sq ? w_hi : w_lo;
      2'd1: w_val = w_lo + w_scaled;
      2'd2: w_val = w_lo + w_scaled;
      2'd3: w_val = XW'(r_s1_bias);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out    <= '0;
      clip        <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      cycle_start <= r_s1_wrap;
      if (w_val[XW-1]) begin
        data_out <= '0;
        clip     <= 1'b1;
      end else if (w_val[DW]) begin
        data_out <= '1;
        clip     <= 1'b1;
      end else begin
        data_out <= w_val[DW-1:0];
        clip     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wavegen_dds.sv
// Directed bench for wavegen_dds: each scenario task checks
// its own samples against hand-derived levels.
module tb_wavegen_dds;

  localparam int DW = 12;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [PW-1:0] phase_inc;
  logic [7:0]    duty;
  logic [DW-1:0] bias;
  logic [DW-1:0] p2p;
  logic [DW-1:0] data_out;
  logic          cycle_start;
  logic          clip;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wavegen_dds #(.DW(DW), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .phase_inc  (phase_inc),
    .duty       (duty),
    .bias       (bias),
    .p2p        (p2p),
    .data_out   (data_out),
    .cycle_start(cycle_start),
    .clip       (clip)
  );

  task automatic load(input logic [1:0] m,
                      input logic [PW-1:0] inc,
                      input logic [7:0] d,
                      input logic [DW-1:0] b,
                      input logic [DW-1:0] p);
    @(negedge clk);
    en = 1'b0;
    mode = m;
    phase_inc = inc;
    duty = d;
    bias = b;
    p2p = p;
    repeat (3) @(negedge clk);
    en = 1'b1;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cycle_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    vecs++;
    if (data_out !== 12'd0) begin
      errs++;
      $display("FAIL reset_data: got %0d want 0", data_out);
    end
    vecs++;
    if (cycle_start !== 1'b0) begin
      errs++;
      $display("FAIL reset_cs: got %b want 0", cycle_start);
    end
    vecs++;
    if (clip !== 1'b0) begin
      errs++;
      $display("FAIL reset_clip: got %b want 0", clip);
    end
  endtask

  task automatic test_square;
    bit ok;
    logic [DW-1:0] exp;
    load(2'd0, 24'h100000, 8'd128, 12'd2048, 12'd1000);
    wait_start(40, ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL sq_start: got none want pulse");
    end
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      exp = ((k % 16) < 8) ? 12'd2548 : 12'd1548;
      vecs++;
      if (data_out !== exp) begin
        errs++;
        $display("FAIL sq_data[%0d]: got %0d want %0d",
                 k, data_out, exp);
      end
      vecs++;
      if (cycle_start !== ((k % 16) == 0)) begin
        errs++;
        $display("FAIL sq_cs[%0d]: got %b", k, cycle_start);
      end
      vecs++;
      if (clip !== 1'b0) begin
        errs++;
        $display("FAIL sq_clip[%0d]: got %b want 0", k, clip);
      end
    end
  endtask

  task automatic test_glitch_free;
    bit ok;
    logic [DW-1:0] exp;
    wait_start(20, ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL gf_start: got none want pulse");
    end
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 16) exp = ((k % 16) < 8) ? 12'd2548 : 12'd1548;
      else        exp = ((k % 16) < 8) ? 12'd3048 : 12'd1048;
      vecs++;
      if (data_out !== exp) begin
        errs++;
        $display("FAIL gf_data[%0d]: got %0d want %0d",
                 k, data_out, exp);
      end
      vecs++;
      if (cycle_start !== ((k % 16) == 0)) begin
        errs++;
        $display("FAIL gf_cs[%0d]: got %b", k, cycle_start);
      end
      if (k == 4) p2p = 12'd2000;
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    load(2'd0, 24'h100000, 8'd128, 12'd2048, 12'd1000);
    wait_start(40, ok);
    vecs++;
    if (!ok || data_out !== 12'd2548) begin
      errs++;
      $display("FAIL ar_pre: got %0d want 2548", data_out);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (data_out !== 12'd0 || cycle_start !== 1'b0 ||
        clip !== 1'b0) begin
      errs++;
      $display("FAIL ar_now: got %0d/%b/%b want 0/0/0",
               data_out, cycle_start, clip);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++;
      if (data_out !== 12'd0 || cycle_start !== 1'b0) begin
        errs++;
        $display("FAIL ar_hold[%0d]: got %0d/%b want 0/0",
                 k, data_out, cycle_start);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++;
      if (data_out !== 12'd0 || cycle_start !== 1'b0 ||
          clip !== 1'b0) begin
        errs++;
        $display("FAIL ar_post[%0d]: got %0d/%b/%b want 0/0/0",
                 k, data_out, cycle_start, clip);
      end
    end
  endtask

  task automatic test_zero_inc;
    load(2'd0, 24'h000000, 8'd128, 12'd2048, 12'd1000);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      vecs++;
      if (data_out !== 12'd2548) begin
        errs++;
        $display("FAIL zi_data[%0d]: got %0d want 2548",
                 k, data_out);
      end
      vecs++;
      if (cycle_start !== 1'b0) begin
        errs++;
        $display("FAIL zi_cs[%0d]: got %b want 0", k, cycle_start);
      end
    end
  endtask

  task automatic test_clamp;
    bit ok;
    logic [DW-1:0] exp;
    logic exp_clip;
    load(2'd0, 24'h100000, 8'd128, 12'd100, 12'd1000);
    wait_start(40, ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL cl_start: got none want pulse");
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      exp      = (k < 8) ? 12'd600 : 12'd0;
      exp_clip = (k >= 8);
      vecs++;
      if (data_out !== exp || clip !== exp_clip) begin
        errs++;
        $display("FAIL cl[%0d]: got %0d/%b want %0d/%b",
                 k, data_out, clip, exp, exp_clip);
      end
    end
  endtask

  task automatic test_triangle;
    bit ok;
    logic [DW-1:0] exp;
    load(2'd1, 24'h100000, 8'd0, 12'd2048, 12'd2048);
    wait_start(40, ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL tr_start: got none want pulse");
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 8) exp = DW'(1024 + 256 * k);
      else       exp = DW'(3071 - 256 * (k - 8));
      vecs++;
      if (data_out !== exp || clip !== 1'b0) begin
        errs++;
        $display("FAIL tr[%0d]: got %0d/%b want %0d/0",
                 k, data_out, clip, exp);
      end
      vecs++;
      if (cycle_start !== (k == 0)) begin
        errs++;
        $display("FAIL tr_cs[%0d]: got %b", k, cycle_start);
      end
    end
  endtask

  task automatic test_sawtooth;
    bit ok;
    int i;
    logic [DW-1:0] exp;
    load(2'd2, 24'h001000, 8'd0, 12'd2048, 12'd4095);
    wait_start(4200, ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL sw_start: got none want pulse");
    end
    for (int k = 0; k <= 4096; k++) begin
      if (k > 0) @(negedge clk);
      i   = k % 4096;
      exp = DW'(1 + ((4095 * i) >>> 12));
      vecs++;
      if (data_out !== exp || clip !== 1'b0) begin
        errs++;
        $display("FAIL sw[%0d]: got %0d/%b want %0d/0",
                 k, data_out, clip, exp);
      end
      vecs++;
      if (cycle_start !== (i == 0)) begin
        errs++;
        $display("FAIL sw_cs[%0d]: got %b", k, cycle_start);
      end
    end
  endtask

  task automatic test_freeze;
    bit ok;
    load(2'd3, 24'h100000, 8'd0, 12'd1234, 12'd500);
    wait_start(40, ok);
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL fz_start: got none want pulse");
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      vecs++;
      if (data_out !== 12'd1234 || cycle_start !== (k == 0)) begin
        errs++;
        $display("FAIL dc[%0d]: got %0d/%b want 1234",
                 k, data_out, cycle_start);
      end
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vecs++;
      if (data_out !== 12'd1234 || cycle_start !== 1'b0) begin
        errs++;
        $display("FAIL fz[%0d]: got %0d/%b want 1234/0",
                 k, data_out, cycle_start);
      end
    end
    bias = 12'd777;
    repeat (2) @(negedge clk);
    vecs++;
    if (data_out !== 12'd777) begin
      errs++;
      $display("FAIL fz_live: got %0d want 777", data_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    phase_inc = '0;
    duty = '0;
    bias = '0;
    p2p = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_square;
    test_glitch_free;
    test_async_reset;
    test_zero_inc;
    test_clamp;
    test_triangle;
    test_sawtooth;
    test_freeze;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
